// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and types.
//   AES_NR   - number of rounds for AES-128
//   aes_block_t - 128-bit state / key word, column 0 in [127:96]
//   RCON     - key schedule round constants for rounds 1..10
//   SBOX     - forward S-box lookup table
//   rcon_of  - RCON lookup that returns 0 outside the table
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [127:0] aes_block_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round index 10 has no successor key, so it maps to a harmless 0.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = '0;
    if (r < 4'd10) v = RCON[r];
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: 8-bit combinational AES forward S-box lookup.
//   a - input byte
//   q - substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] q
);

  assign q = SBOX[a];

endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage: registered AES-128 AddRoundKey with an iterative
// on-the-fly key schedule. Each accepted beat is XORed with the current
// round key, then the schedule advances; after round NR it rewinds to the
// cipher key so consecutive blocks need no reload.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   key_load, key_in     - capture cipher key, rewind schedule to round 0
//   in_valid, in_ready   - input handshake for state_in
//   state_in             - 128-bit state, column 0 in [127:96]
//   out_valid, out_ready - output handshake
//   state_out            - state_in ^ round key (registered)
//   round_out            - round index of the applied key
//   last_out             - high with the round-NR beat
//   rk_out               - applied round key (only with ADD_ROUND_KEY_RK_OUT_EN)
//
// Build option: define ADD_ROUND_KEY_RK_OUT_EN to add the rk_out port.
module add_round_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [3:0]   round_out,
  output logic         last_out
`ifdef ADD_ROUND_KEY_RK_OUT_EN
  ,
  output logic [127:0] rk_out
`endif
);

  if (NR != AES_NR) begin : g_nr_check
    $error("add_round_key_stage: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_block_t ck;
  aes_block_t rk;
  logic [3:0] rnd;
  logic       key_valid;
  logic       accept;
  logic [31:0] rot_w3;
  logic [31:0] sub_w3;
  aes_block_t  rk_next;

  // One schedule step; SubWord(RotWord(w3)) is computed by the S-box
  // instances outside so the function stays pure XOR logic.
  function automatic aes_block_t expand(input aes_block_t k,
                                        input logic [31:0] sub,
                                        input logic [7:0]  rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign rot_w3 = {rk[23:0], rk[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w3[8*i +: 8]),
      .q (sub_w3[8*i +: 8])
    );
  end

  assign rk_next  = expand(rk, sub_w3, rcon_of(rnd));
  assign in_ready = key_valid & ~key_load & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ck        <= '0;
      rk        <= '0;
      rnd       <= '0;
      key_valid <= 1'b0;
      out_valid <= 1'b0;
      state_out <= '0;
      round_out <= '0;
      last_out  <= 1'b0;
    end else begin
      if (key_load) begin
        ck        <= key_in;
        rk        <= key_in;
        rnd       <= '0;
        key_valid <= 1'b1;
      end else if (accept) begin
        if (rnd == LAST_RND) begin
          rk  <= ck;
          rnd <= '0;
        end else begin
          rk  <= rk_next;
          rnd <= rnd + 4'd1;
        end
      end

      // Output register runs independently of key_load so a pending beat
      // can still drain during a reload cycle.
      if (accept) begin
        state_out <= state_in ^ rk;
        round_out <= rnd;
        last_out  <= (rnd == LAST_RND);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ADD_ROUND_KEY_RK_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_out <= '0;
    end else if (accept) begin
      rk_out <= rk;
    end
  end
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round_out;
  logic         last_out;
`ifdef ADD_ROUND_KEY_RK_OUT_EN
  logic [127:0] rk_out;
`endif

  always #5 clk = ~clk;

  add_round_key_stage #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .round_out (round_out),
    .last_out  (last_out)
`ifdef ADD_ROUND_KEY_RK_OUT_EN
    ,
    .rk_out    (rk_out)
`endif
  );

  typedef struct {
    logic [127:0] state;
    logic [127:0] key;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // FIPS-197 round keys for key 2b7e1516...
  logic [127:0] keys_a [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  // First two round keys for key 000102...0f
  logic [127:0] key_b    = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] key_b_r1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic [127:0] ktab [11];
  int unsigned  model_rnd;
  logic [127:0] last_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per completed output transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got state %h round %0d, expected no output", state_out, round_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("state_out", state_out, e.state);
        check("round_out", {124'h0, round_out}, {124'h0, e.rnd});
        check("last_out", {127'h0, last_out}, {127'h0, e.last});
`ifdef ADD_ROUND_KEY_RK_OUT_EN
        check("rk_out", rk_out, e.key);
`endif
      end
    end
  end

  // Drive one beat; assumes entry just after a rising edge.
  task automatic send(input logic [127:0] st);
    bit done = 0;
    exp_t e;
    in_valid = 1'b1;
    state_in = st;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e.state = st ^ ktab[model_rnd];
        e.key   = ktab[model_rnd];
        e.rnd   = 4'(model_rnd);
        e.last  = (model_rnd == 10);
        exp_q.push_back(e);
        last_exp = e.state;
        model_rnd = (model_rnd == 10) ? 0 : model_rnd + 1;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0;
    in_valid = 1'b1; state_in = 128'h1234; out_ready = 1'b1;
    model_rnd = 0; last_exp = '0;
    for (int i = 0; i < 11; i++) ktab[i] = keys_a[i];

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", {127'h0, out_valid}, '0);
    check("rst_state_out", state_out, '0);
    check("rst_round_out", {124'h0, round_out}, '0);
    check("rst_last_out", {127'h0, last_out}, '0);
    check("rst_in_ready", {127'h0, in_ready}, '0);

    // No key loaded yet: inputs must be ignored.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nokey_in_ready", {127'h0, in_ready}, '0);
      check("nokey_out_valid", {127'h0, out_valid}, '0);
      @(posedge clk); #1;
    end

    // Load key A.
    in_valid = 1'b0;
    key_load = 1'b1; key_in = keys_a[0];
    @(posedge clk); #1;
    key_load = 1'b0;

    // Full block of zero beats back to back, then a wrap beat.
    for (int i = 0; i < 11; i++) send('0);
    send(128'h00112233445566778899aabbccddeeff);

    // Rounds 1..3 of the second block.
    send(128'hdeadbeef0123456789abcdeffedcba98);
    send(128'h0f0e0d0c0b0a09080706050403020100);
    send(128'h3243f6a8885a308d313198a2e0370734);

    // Back-pressure with a round-3 beat pending.
    out_ready = 1'b0;
    state_in = 128'hffffffffffffffffffffffffffffffff;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {127'h0, in_ready}, '0);
      check("bp_out_valid", {127'h0, out_valid}, 128'h1);
      check("bp_state_hold", state_out, last_exp);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(128'hffffffffffffffffffffffffffffffff);

    // Reload while the round-4 beat is pending; it must drain unchanged.
    key_load = 1'b1; key_in = key_b;
    state_in = 128'h55555555555555555555555555555555;
    @(negedge clk);
    check("kl_in_ready", {127'h0, in_ready}, '0);
    @(posedge clk); #1;
    key_load = 1'b0;
    model_rnd = 0;
    ktab[0] = key_b;
    ktab[1] = key_b_r1;
    send(128'h00112233445566778899aabbccddeeff);
    send('0);
    in_valid = 1'b0;

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), '0);
    check("idle_out_valid", {127'h0, out_valid}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
